demux_dispatch: RTL and testbench
=================================

Name: demux_dispatch

Overview:
Upstream feeder for the 2-lane 1:2 demultiplexer (2-bit data, Select 0 -> lane B, 1 -> lane C). It accepts a stream of 2-bit symbols over a valid/ready handshake and buffers them in a small FIFO. It drives the demux data input and Select so that symbols alternate between lanes B and C in bursts of BURST symbols. Each lane has its own valid/ready pair, so a stalled lane back-pressures the whole stream without reordering.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
BURST, 1, symbols sent to one lane before switching to the other; >= 1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of FIFO and lane state
in_data  input  2  incoming symbol
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a symbol this cycle
out_data  output  2  symbol to the demux data input (A_in)
out_sel  output  1  demux Select; 0 = lane B, 1 = lane C
out_valid_b  output  1  symbol on out_data is valid for lane B
out_valid_c  output  1  symbol on out_data is valid for lane C
ready_b  input  1  lane B consumer accepts this cycle
ready_c  input  1  lane C consumer accepts this cycle
fifo_count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low. Every flop clears immediately when rst_n is low and releases on the first clk edge after rst_n goes high.
- Reset values: FIFO pointers 0; fifo_count 0; burst counter 0; lane state LANE_B (out_sel 0); out_valid_b 0; out_valid_c 0; out_data 2'b00; in_ready 0 while rst_n is low, 1 after release.
- Push: occurs when in_valid && in_ready.
  - in_ready = !full && !flush && rst_n.
  - When full, in_ready is 0 even if a pop occurs in the same cycle. There is no write-through on full.
- Head presentation: out_data = FIFO head when not empty, else 2'b00 (demux lines idle low). out_data is driven combinationally from registered storage.
- Lane valids: out_valid_b = !empty && lane==LANE_B; out_valid_c = !empty && lane==LANE_C. Exactly one or none is high.
- Pop: occurs when (out_valid_b && ready_b) || (out_valid_c && ready_c). The ready of the inactive lane is ignored.
- Latency: a symbol pushed into an empty FIFO appears on out_data with its lane valid on the next cycle (1-cycle latency).
- Simultaneous push and pop (not full, not empty): count is unchanged and both pointers advance.
- Lane FSM, two states:
  - LANE_B (out_sel 0) and LANE_C (out_sel 1).
  - On each pop the burst counter increments.
  - On a pop with burst counter == BURST-1, the counter returns to 0 and the state toggles. The new out_sel is effective the next cycle.
  - No toggle without a pop. A stalled lane holds state, head and out_sel indefinitely; the other lane is never skipped to.
- out_sel is a registered output and changes only on a clk edge. It never glitches mid-symbol.
- Pointer arithmetic: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. full/empty come from fifo_count (full: count == DEPTH; empty: count == 0).
- Flush:
  - Synchronous and takes priority over push and pop in the same cycle.
  - Next state: pointers 0, count 0, burst counter 0, lane LANE_B.
  - The push or pop attempted in the flush cycle is discarded.
- Reset mid-operation: all buffered symbols are lost and the outputs take their reset values asynchronously.
- Ignored inputs: in_data is ignored when no push occurs. ready_b and ready_c are ignored when the FIFO is empty.

Decomposition:
- Shared package demux_pkg:
  - SYM_W = 2.
  - Lane encoding LANE_B = 1'b0, LANE_C = 1'b1. The demux must use the same mapping.
  - typedef sym_t (2-bit symbol).
  - typedef lane_t (1-bit lane).
- Sub-module sym_fifo: parameterised synchronous FIFO (DEPTH, width SYM_W) with push, pop, flush, head, count, full and empty.
- demux_dispatch holds the lane FSM, burst counter and handshake glue.

Test Plan:
1. Reset, then BURST=1; push 2'b01, 2'b10, 2'b11, 2'b00 with ready_b = ready_c = 1 -> lane B receives 01 then 11, lane C receives 10 then 00; out_sel toggles each cycle; fifo_count returns to 0.
2. BURST=2; push 01, 10, 11, 00, all ready -> B receives 01 and 10, then C receives 11 and 00; out_sel = 0,0,1,1.
3. DEPTH=4; ready_b = 0; push 5 symbols -> first 4 accepted, fifo_count = 4, in_ready = 0; 5th held by the source until a pop. Raising ready_b pops one symbol and the 5th is accepted the following cycle.
4. Lane C stalled: ready_c = 0 while lane = LANE_C with symbols queued -> out_valid_c stays 1, out_data and out_sel stay stable, out_valid_b stays 0, no symbol reaches B.
5. fifo_count = 3, assert flush together with in_valid and a pop-enabling ready -> next cycle fifo_count = 0, out_sel = 0, out_data = 00, both valids 0; the flush-cycle symbol is discarded.
6. Drop rst_n asynchronously mid-burst with fifo_count = 2 -> outputs take reset values before the next clk edge; after release in_ready = 1 and the next symbol goes to lane B.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types for the demux feeder: symbol width, lane encoding and the
// lane-toggle helper. The demultiplexer uses the same lane mapping.
package demux_pkg;

    localparam int SYM_W = 2;

    typedef logic [SYM_W-1:0] sym_t;

    // Select 0 routes to lane B, Select 1 routes to lane C.
    typedef enum logic {
        LANE_B = 1'b0,
        LANE_C = 1'b1
    } lane_t;

    // Lane the dispatcher moves to once a burst completes.
    function automatic lane_t next_lane(input lane_t cur);
        return (cur == LANE_B) ? LANE_C : LANE_B;
    endfunction

endpackage

// File: rtl/demux_if.sv
// Handshake bundle between the symbol source, the dispatcher and the two
// demux lanes. The slave modport is the dispatcher's view.
interface demux_if #(
    parameter int DEPTH = 4
);
    import demux_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             flush;
    sym_t             in_data;
    logic             in_valid;
    logic             in_ready;
    sym_t             out_data;
    logic             out_sel;
    logic             out_valid_b;
    logic             out_valid_c;
    logic             ready_b;
    logic             ready_c;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        output flush, in_data, in_valid, ready_b, ready_c,
        input  in_ready, out_data, out_sel, out_valid_b, out_valid_c, fifo_count
    );

    modport slave (
        input  flush, in_data, in_valid, ready_b, ready_c,
        output in_ready, out_data, out_sel, out_valid_b, out_valid_c, fifo_count
    );

endinterface

// File: rtl/demux_dispatch_fifo.sv
// Small synchronous symbol FIFO. Occupancy is kept as an explicit counter so
// full/empty never depend on pointer comparison. srst clears pointers and
// count and overrides any push or pop in the same cycle.
module sym_fifo
    import demux_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  sym_t             wr_data,
    output sym_t             head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    sym_t             mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == CNT_W'(0));
    assign count     = count_r;
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Head of queue; idle-low when nothing is buffered.
    always_comb begin
        head = SYM_W'(0);
        if (!empty) begin
            head = mem_r[rd_ptr_r];
        end else begin
            head = SYM_W'(0);
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else if (srst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Symbol storage; written only on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= SYM_W'(0);
            end
        end else if (!srst && do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/demux_dispatch.sv
// Upstream feeder for the 2-lane demux. Buffers incoming symbols and hands
// them out alternately to lane B and lane C in bursts of BURST symbols.
// A stalled lane holds the whole stream; lanes are never skipped.
module demux_dispatch
    import demux_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int BURST = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    demux_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int BC_W  = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST - 1);

    lane_t            lane_r;
    logic [BC_W-1:0]  burst_r;
    sym_t             head_s;
    logic [CNT_W-1:0] count_s;
    logic             full_s;
    logic             empty_s;
    logic             in_ready_s;
    logic             push_s;
    logic             pop_s;
    logic             valid_b_s;
    logic             valid_c_s;

    sym_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .srst    (bus.flush),
        .push    (push_s),
        .pop     (pop_s),
        .wr_data (bus.in_data),
        .head    (head_s),
        .count   (count_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Handshake glue: no write-through when full, nothing accepted during flush or reset.
    always_comb begin
        in_ready_s = !full_s && !bus.flush && rst_n;
        push_s     = bus.in_valid && in_ready_s;
        valid_b_s  = !empty_s && (lane_r == LANE_B);
        valid_c_s  = !empty_s && (lane_r == LANE_C);
        pop_s      = (valid_b_s && bus.ready_b) || (valid_c_s && bus.ready_c);
    end

    // Lane FSM with burst counter; the lane only advances on a pop that closes a burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_r  <= LANE_B;
            burst_r <= BC_W'(0);
        end else if (bus.flush) begin
            lane_r  <= LANE_B;
            burst_r <= BC_W'(0);
        end else if (pop_s) begin
            if (burst_r == BURST_LAST) begin
                burst_r <= BC_W'(0);
                lane_r  <= next_lane(lane_r);
            end else begin
                burst_r <= burst_r + BC_W'(1);
                lane_r  <= lane_r;
            end
        end else begin
            lane_r  <= lane_r;
            burst_r <= burst_r;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_data    = head_s;
    assign bus.out_sel     = lane_r;
    assign bus.out_valid_b = valid_b_s;
    assign bus.out_valid_c = valid_c_s;
    assign bus.fifo_count  = count_s;

endmodule

// File: tb/tb_demux_dispatch.sv
// Bench for demux_dispatch: two instances (BURST=1 and BURST=2) share one
// stimulus stream; a queue-based reference model predicts both.
module tb_demux_dispatch;
    import demux_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       ready_b;
    logic       ready_c;
    logic [1:0] in_data;

    always #5 clk = ~clk;

    demux_if #(.DEPTH(DEPTH)) bus1 ();
    demux_if #(.DEPTH(DEPTH)) bus2 ();

    assign bus1.flush    = flush;
    assign bus1.in_data  = in_data;
    assign bus1.in_valid = in_valid;
    assign bus1.ready_b  = ready_b;
    assign bus1.ready_c  = ready_c;
    assign bus2.flush    = flush;
    assign bus2.in_data  = in_data;
    assign bus2.in_valid = in_valid;
    assign bus2.ready_b  = ready_b;
    assign bus2.ready_c  = ready_c;

    demux_dispatch #(.DEPTH(DEPTH), .BURST(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    demux_dispatch #(.DEPTH(DEPTH), .BURST(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int checks   = 0;
    int failures = 0;

    // Reference model: one queue per instance, current lane and symbols sent in this burst.
    logic [1:0] q1[$];
    logic [1:0] q2[$];
    int         mlane  [2];
    int         mburst [2];

    logic [1:0] syms [4] = '{2'b01, 2'b10, 2'b11, 2'b00};

    function automatic int msize(input int k);
        return (k == 0) ? q1.size() : q2.size();
    endfunction

    function automatic logic [1:0] mhead(input int k);
        if (msize(k) == 0) return 2'b00;
        return (k == 0) ? q1[0] : q2[0];
    endfunction

    // Expected {in_ready, out_data, out_sel, out_valid_b, out_valid_c, fifo_count}.
    function automatic logic [8:0] mexp(input int k);
        logic ir, vb, vc;
        ir = rst_n && !flush && (msize(k) < DEPTH);
        vb = (msize(k) > 0) && (mlane[k] == 0);
        vc = (msize(k) > 0) && (mlane[k] == 1);
        return {ir, mhead(k), (mlane[k] == 1), vb, vc, 3'(msize(k))};
    endfunction

    function automatic logic [8:0] observed(input int k);
        if (k == 0)
            return {bus1.in_ready, bus1.out_data, bus1.out_sel, bus1.out_valid_b,
                    bus1.out_valid_c, bus1.fifo_count};
        return {bus2.in_ready, bus2.out_data, bus2.out_sel, bus2.out_valid_b,
                bus2.out_valid_c, bus2.fifo_count};
    endfunction

    task automatic model_reset();
        q1.delete();
        q2.delete();
        for (int k = 0; k < 2; k++) begin
            mlane[k]  = 0;
            mburst[k] = 0;
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int  sz;
        int  bl;
        bit  pop;
        bit  push;
        for (int k = 0; k < 2; k++) begin
            sz = msize(k);
            bl = (k == 0) ? 1 : 2;
            if (!rst_n || flush) begin
                if (k == 0) q1.delete(); else q2.delete();
                mlane[k]  = 0;
                mburst[k] = 0;
            end else begin
                pop  = (sz > 0) && ((mlane[k] == 0 && ready_b) || (mlane[k] == 1 && ready_c));
                push = in_valid && (sz < DEPTH);
                if (pop) begin
                    if (k == 0) void'(q1.pop_front()); else void'(q2.pop_front());
                    mburst[k]++;
                    if (mburst[k] == bl) begin
                        mburst[k] = 0;
                        mlane[k]  = 1 - mlane[k];
                    end
                end
                if (push) begin
                    if (k == 0) q1.push_back(in_data); else q2.push_back(in_data);
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 2'b00;
        ready_b = 1'b0; ready_c = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (observed(k) !== 9'd0) begin
                failures++;
                $display("FAIL reset_state dut%0d got=%b expected=%b", k + 1, observed(k), 9'd0);
            end
        end
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (observed(k) !== mexp(k) || observed(k)[8] !== 1'b1) begin
                failures++;
                $display("FAIL reset_release dut%0d got=%b expected=%b", k + 1, observed(k), mexp(k));
            end
        end
    endtask

    task automatic test_burst();
        logic [7:0] rb [2];
        logic [7:0] rc [2];
        logic [7:0] sl [2];
        int         np [2];
        logic [8:0] o;
        for (int k = 0; k < 2; k++) begin
            rb[k] = 8'd0; rc[k] = 8'd0; sl[k] = 8'd0; np[k] = 0;
        end
        for (int i = 0; i < 16; i++) begin
            in_valid = (i < 4);
            in_data  = syms[i % 4];
            ready_b  = 1'b1;
            ready_c  = 1'b1;
            #1;
            for (int k = 0; k < 2; k++) begin
                o = observed(k);
                if (o[4]) rb[k] = {rb[k][5:0], o[7:6]};
                if (o[3]) rc[k] = {rc[k][5:0], o[7:6]};
                if (o[4] || o[3]) begin
                    sl[k] = {sl[k][6:0], o[5]};
                    np[k]++;
                end
            end
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (rb[0] !== 8'h07 || rc[0] !== 8'h08) begin
            failures++;
            $display("FAIL burst1_lanes got B=%h C=%h expected B=07 C=08", rb[0], rc[0]);
        end
        checks++;
        if (sl[0] !== 8'h05 || np[0] != 4) begin
            failures++;
            $display("FAIL burst1_sel got sel=%b pops=%0d expected sel=00000101 pops=4", sl[0], np[0]);
        end
        checks++;
        if (rb[1] !== 8'h06 || rc[1] !== 8'h0c) begin
            failures++;
            $display("FAIL burst2_lanes got B=%h C=%h expected B=06 C=0c", rb[1], rc[1]);
        end
        checks++;
        if (sl[1] !== 8'h03 || np[1] != 4) begin
            failures++;
            $display("FAIL burst2_sel got sel=%b pops=%0d expected sel=00000011 pops=4", sl[1], np[1]);
        end
        checks++;
        if (bus1.fifo_count !== 3'd0 || bus2.fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL burst_drain got counts=%0d,%0d expected 0,0", bus1.fifo_count, bus2.fifo_count);
        end
    endtask

    task automatic test_full();
        int acc;
        flush = 1'b1; in_valid = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
        tick();
        flush = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = (acc >= 4) ? 2'b10 : syms[acc];
            #1;
            if (bus1.in_ready) acc++;
            tick();
        end
        checks++;
        if (bus1.fifo_count !== 3'd4 || bus2.fifo_count !== 3'd4 || bus1.in_ready !== 1'b0 || acc != 4) begin
            failures++;
            $display("FAIL full_stop got counts=%0d,%0d in_ready=%b accepted=%0d expected 4,4 0 4",
                     bus1.fifo_count, bus2.fifo_count, bus1.in_ready, acc);
        end
        ready_b = 1'b1;
        #1;
        checks++;
        if (bus1.in_ready !== 1'b0 || bus2.in_ready !== 1'b0 || bus1.out_data !== 2'b01) begin
            failures++;
            $display("FAIL full_pop_no_write_through got in_ready=%b,%b head=%b expected 0,0 01",
                     bus1.in_ready, bus2.in_ready, bus1.out_data);
        end
        tick();
        ready_b = 1'b0;
        #1;
        checks++;
        if (bus1.fifo_count !== 3'd3 || bus1.in_ready !== 1'b1 || bus2.fifo_count !== 3'd3) begin
            failures++;
            $display("FAIL full_after_pop got counts=%0d,%0d in_ready=%b expected 3,3 1",
                     bus1.fifo_count, bus2.fifo_count, bus1.in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (bus1.fifo_count !== 3'd4 || bus2.fifo_count !== 3'd4) begin
            failures++;
            $display("FAIL full_fifth_accept got counts=%0d,%0d expected 4,4", bus1.fifo_count, bus2.fifo_count);
        end
    endtask

    task automatic test_stall_c();
        // Instance 1 has just closed a one-symbol burst on B, so it now waits on lane C.
        ready_c = 1'b0; ready_b = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if ({bus1.out_valid_c, bus1.out_valid_b, bus1.out_sel, bus1.out_data, bus1.fifo_count}
                    !== {1'b1, 1'b0, 1'b1, 2'b10, 3'd4}) begin
                failures++;
                $display("FAIL stall_c cycle=%0d got vc=%b vb=%b sel=%b data=%b count=%0d expected 1 0 1 10 4",
                         i, bus1.out_valid_c, bus1.out_valid_b, bus1.out_sel, bus1.out_data, bus1.fifo_count);
            end
            tick();
        end
        ready_b = 1'b0;
    endtask

    task automatic test_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = syms[i];
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++;
        if (bus1.fifo_count !== 3'd3) begin
            failures++;
            $display("FAIL flush_setup got count=%0d expected 3", bus1.fifo_count);
        end
        flush = 1'b1; in_valid = 1'b1; in_data = 2'b11; ready_b = 1'b1; ready_c = 1'b1;
        #1;
        checks++;
        if (bus1.in_ready !== 1'b0 || bus2.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_in_ready got %b,%b expected 0,0", bus1.in_ready, bus2.in_ready);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (observed(k)[7:0] !== 8'd0) begin
                failures++;
                $display("FAIL flush_clear dut%0d got=%b expected=00000000", k + 1, observed(k)[7:0]);
            end
        end
        tick();
        checks++;
        if (bus1.fifo_count !== 3'd0 || bus2.fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL flush_discard got counts=%0d,%0d expected 0,0", bus1.fifo_count, bus2.fifo_count);
        end
        ready_b = 1'b0; ready_c = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = syms[i];
            tick();
        end
        in_valid = 1'b0; ready_b = 1'b1;
        tick();
        ready_b = 1'b0;
        #1;
        checks++;
        if (bus1.fifo_count !== 3'd2 || bus2.fifo_count !== 3'd2) begin
            failures++;
            $display("FAIL areset_setup got counts=%0d,%0d expected 2,2", bus1.fifo_count, bus2.fifo_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (observed(k) !== 9'd0) begin
                failures++;
                $display("FAIL areset_async dut%0d got=%b expected=%b", k + 1, observed(k), 9'd0);
            end
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_data = 2'b11;
        #1;
        checks++;
        if (bus1.in_ready !== 1'b1 || bus2.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL areset_in_ready got %b,%b expected 1,1", bus1.in_ready, bus2.in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (observed(k) !== {1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 3'd1}) begin
                failures++;
                $display("FAIL areset_first_lane_b dut%0d got=%b expected=%b", k + 1, observed(k),
                         {1'b1, 2'b11, 1'b0, 1'b1, 1'b0, 3'd1});
            end
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 2'($urandom);
            ready_b  = ($urandom_range(0, 2) != 0);
            ready_c  = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 39) == 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (observed(k) !== mexp(k)) begin
                    failures++;
                    $display("FAIL random dut%0d cycle=%0d got=%b expected=%b", k + 1, i, observed(k), mexp(k));
                end
            end
            tick();
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_burst();
        test_full();
        test_stall_c();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
